bus_arbiter: RTL and testbench

//   Shares the single memory bus between two masters: m0 = maxicore32 CPU, m1 = a secondary master (DMA/video fetch).

---
 rtl/bus_arbiter_pkg.sv | 16 +
 rtl/bus_address_decoder.sv | 32 +++
 rtl/bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
//   - Bus widths: word address, data and byte-lane strobes.
//   - Ownership FSM state encoding.
package bus_arbiter_pkg;

    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STROBE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_address_decoder.sv
// Access checker for the owning master's bus cycle (purely combinational).
//   address       in   word address of the current access
//   read, write   in   access type (already muxed from the owner)
//   data_strobes  in   byte lanes of the access
//   error         out  access is unmapped, has read and write together, or writes no lanes
module bus_address_decoder
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 16384
) (
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [STROBE_W-1:0] data_strobes,
    output logic                error
);

    // One extra bit so MEM_WORDS = 2^30 maps the whole address space.
    localparam logic [ADDR_W:0] MemLimit = (ADDR_W + 1)'(MEM_WORDS);

    logic unmapped;
    logic rw_clash;
    logic no_lanes;

    always_comb begin
        unmapped = (read | write) && ({1'b0, address} >= MemLimit);
        rw_clash = read & write;
        no_lanes = write && (data_strobes == '0);
        error    = unmapped | rw_clash | no_lanes;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the single memory bus (m0 = CPU, m1 = DMA/video fetch).
//   clock, reset              system clock; synchronous active-high reset
//   mN_req                    master N wants the bus (held for the whole transfer/burst)
//   mN_address/data_out/...   master N access; only the owner's signals reach memory
//   mN_grant                  master N owns the bus this cycle (decoded from registered state)
//   mN_data_in                memory read data, broadcast to both masters
//   mN_bus_error              owner's current access is illegal; suppressed at memory
//   address/data_out/...      memory side of the bus, all zero while idle
//   data_in                   memory read data
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 16384,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W-1:0]   m0_data_out,
    input  logic [STROBE_W-1:0] m0_data_strobes,
    input  logic                m0_read,
    input  logic                m0_write,
    output logic                m0_grant,
    output logic [DATA_W-1:0]   m0_data_in,
    output logic                m0_bus_error,

    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W-1:0]   m1_data_out,
    input  logic [STROBE_W-1:0] m1_data_strobes,
    input  logic                m1_read,
    input  logic                m1_write,
    output logic                m1_grant,
    output logic [DATA_W-1:0]   m1_data_in,
    output logic                m1_bus_error,

    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   data_out,
    output logic [STROBE_W-1:0] data_strobes,
    output logic                read,
    output logic                write,
    input  logic [DATA_W-1:0]   data_in
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_BURST);

    arb_state_e      state_q, state_d;
    logic            last_owner_q, last_owner_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

    logic [CntW-1:0] burst_cnt_inc;
    logic            limit_hit;

    logic [ADDR_W-1:0]   own_address;
    logic [DATA_W-1:0]   own_data_out;
    logic [STROBE_W-1:0] own_strobes;
    logic                own_read;
    logic                own_write;
    logic                access_error;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= 1'b1;  // makes m0 win the first tie
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;

        burst_cnt_inc = (burst_cnt_q == CntMax) ? burst_cnt_q : burst_cnt_q + 1'b1;
        // >= rather than == so an owner that ran alone past the limit still yields at once.
        limit_hit     = (burst_cnt_q >= CntLast);

        unique case (state_q)
            ARB_IDLE: begin
                burst_cnt_d = '0;
                if (m0_req && m1_req) begin
                    state_d = ((FIXED_PRI != 0) || last_owner_q) ? ARB_OWN0 : ARB_OWN1;
                end else if (m0_req) begin
                    state_d = ARB_OWN0;
                end else if (m1_req) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0: begin
                if (!m0_req || (limit_hit && m1_req)) begin
                    state_d      = m1_req ? ARB_OWN1 : ARB_IDLE;
                    last_owner_d = 1'b0;
                    burst_cnt_d  = '0;
                end else begin
                    burst_cnt_d = burst_cnt_inc;
                end
            end
            ARB_OWN1: begin
                if (!m1_req || (limit_hit && m0_req)) begin
                    state_d      = m0_req ? ARB_OWN0 : ARB_IDLE;
                    last_owner_d = 1'b1;
                    burst_cnt_d  = '0;
                end else begin
                    burst_cnt_d = burst_cnt_inc;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Output logic: grant decode and owner mux
    always_comb begin
        m0_grant     = (state_q == ARB_OWN0);
        m1_grant     = (state_q == ARB_OWN1);
        own_address  = '0;
        own_data_out = '0;
        own_strobes  = '0;
        own_read     = 1'b0;
        own_write    = 1'b0;

        unique case (state_q)
            ARB_OWN0: begin
                own_address  = m0_address;
                own_data_out = m0_data_out;
                own_strobes  = m0_data_strobes;
                own_read     = m0_read;
                own_write    = m0_write;
            end
            ARB_OWN1: begin
                own_address  = m1_address;
                own_data_out = m1_data_out;
                own_strobes  = m1_data_strobes;
                own_read     = m1_read;
                own_write    = m1_write;
            end
            default: ;
        endcase

        address      = own_address;
        data_out     = own_data_out;
        data_strobes = own_strobes;
        // Errored accesses never reach memory; nor does anything in a reset cycle,
        // so a transfer cut short by reset cannot commit a write.
        read         = own_read  & ~access_error & ~reset;
        write        = own_write & ~access_error & ~reset;
        m0_bus_error = m0_grant & access_error;
        m1_bus_error = m1_grant & access_error;
        m0_data_in   = data_in;
        m1_data_in   = data_in;
    end

    bus_address_decoder #(
        .MEM_WORDS (MEM_WORDS)
    ) u_decoder (
        .address      (own_address),
        .read         (own_read),
        .write        (own_write),
        .data_strobes (own_strobes),
        .error        (access_error)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
// Instance "a" is round-robin (with a small memory model), instance "b" is fixed priority.
module tb_bus_arbiter;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        e0;
        logic        e1;
        logic        rd;
        logic        wr;
        logic [3:0]  stb;
        logic [29:0] adr;
    } obs_t;

    typedef struct {
        int          kind;     // 0 = bus cycle, 1 = memory word
        bit          sel;      // 0 = instance a, 1 = instance b
        obs_t        o;
        bit          chk_din;
        logic [31:0] din;
        int          midx;
        logic [31:0] mval;
        int          tag;
    } exp_t;

    logic clock;
    logic reset;
    logic mem_init;

    logic        a_req [2];
    logic        a_rd  [2];
    logic        a_wr  [2];
    logic [29:0] a_adr [2];
    logic [3:0]  a_stb [2];
    logic [31:0] a_wd  [2];
    logic        b_req [2];
    logic        b_rd  [2];
    logic        b_wr  [2];
    logic [29:0] b_adr [2];
    logic [3:0]  b_stb [2];
    logic [31:0] b_wd  [2];

    logic        a_g0, a_g1, a_e0, a_e1, a_read, a_write;
    logic [29:0] a_address;
    logic [31:0] a_dout, a_din0, a_din1, a_mem_din;
    logic [3:0]  a_strb;
    logic        b_g0, b_g1, b_e0, b_e1, b_read, b_write;
    logic [29:0] b_address;
    logic [31:0] b_dout, b_din0, b_din1;
    logic [31:0] b_mem_din;
    logic [3:0]  b_strb;

    logic [31:0] mem [256];

    exp_t q[$];
    int   checks;
    int   errors;
    int   tnum;

    bus_arbiter #(.MEM_WORDS(16384), .MAX_BURST(8), .FIXED_PRI(0)) dut (
        .clock(clock), .reset(reset),
        .m0_req(a_req[0]), .m0_address(a_adr[0]), .m0_data_out(a_wd[0]),
        .m0_data_strobes(a_stb[0]), .m0_read(a_rd[0]), .m0_write(a_wr[0]),
        .m0_grant(a_g0), .m0_data_in(a_din0), .m0_bus_error(a_e0),
        .m1_req(a_req[1]), .m1_address(a_adr[1]), .m1_data_out(a_wd[1]),
        .m1_data_strobes(a_stb[1]), .m1_read(a_rd[1]), .m1_write(a_wr[1]),
        .m1_grant(a_g1), .m1_data_in(a_din1), .m1_bus_error(a_e1),
        .address(a_address), .data_out(a_dout), .data_strobes(a_strb),
        .read(a_read), .write(a_write), .data_in(a_mem_din)
    );

    bus_arbiter #(.MEM_WORDS(16384), .MAX_BURST(8), .FIXED_PRI(1)) dut_fp (
        .clock(clock), .reset(reset),
        .m0_req(b_req[0]), .m0_address(b_adr[0]), .m0_data_out(b_wd[0]),
        .m0_data_strobes(b_stb[0]), .m0_read(b_rd[0]), .m0_write(b_wr[0]),
        .m0_grant(b_g0), .m0_data_in(b_din0), .m0_bus_error(b_e0),
        .m1_req(b_req[1]), .m1_address(b_adr[1]), .m1_data_out(b_wd[1]),
        .m1_data_strobes(b_stb[1]), .m1_read(b_rd[1]), .m1_write(b_wr[1]),
        .m1_grant(b_g1), .m1_data_in(b_din1), .m1_bus_error(b_e1),
        .address(b_address), .data_out(b_dout), .data_strobes(b_strb),
        .read(b_read), .write(b_write), .data_in(b_mem_din)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model for instance a: combinational read, byte-lane write on the rising edge.
    assign a_mem_din = mem[a_address[7:0]];
    assign b_mem_din = 32'h0;

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hCAFE_0000 | i;
        end else if (a_write) begin
            for (int l = 0; l < 4; l++) begin
                if (a_strb[l]) mem[a_address[7:0]][8*l +: 8] <= a_dout[8*l +: 8];
            end
        end
    end

    // Monitor
    always @(negedge clock) begin
        exp_t e;
        obs_t act;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.kind == 1) begin
                checks++;
                if (mem[e.midx] !== e.mval) begin
                    errors++;
                    $display("FAIL t%0d mem[%0d]: got %h want %h", e.tag, e.midx, mem[e.midx],
                             e.mval);
                end
            end else begin
                act = e.sel ? {b_g0, b_g1, b_e0, b_e1, b_read, b_write, b_strb, b_address}
                            : {a_g0, a_g1, a_e0, a_e1, a_read, a_write, a_strb, a_address};
                checks++;
                if (act !== e.o) begin
                    errors++;
                    $display("FAIL t%0d bus%0d g0g1e0e1rdwr: got %b%b%b%b%b%b stb %h adr %h want %b%b%b%b%b%b stb %h adr %h",
                             e.tag, e.sel, act.g0, act.g1, act.e0, act.e1, act.rd, act.wr,
                             act.stb, act.adr, e.o.g0, e.o.g1, e.o.e0, e.o.e1, e.o.rd, e.o.wr,
                             e.o.stb, e.o.adr);
                end
                if (e.chk_din) begin
                    checks++;
                    if (a_din0 !== e.din || a_din1 !== e.din) begin
                        errors++;
                        $display("FAIL t%0d data_in: got m0 %h m1 %h want %h", e.tag, a_din0,
                                 a_din1, e.din);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_m(input bit sel, input int idx, input logic req, input logic rd,
                         input logic wr, input logic [29:0] adr, input logic [3:0] stb);
        logic [31:0] wd;
        wd = {1'b1, (idx != 0), adr};
        if (!sel) begin
            a_req[idx] = req; a_rd[idx] = rd; a_wr[idx] = wr;
            a_adr[idx] = adr; a_stb[idx] = stb; a_wd[idx] = wd;
        end else begin
            b_req[idx] = req; b_rd[idx] = rd; b_wr[idx] = wr;
            b_adr[idx] = adr; b_stb[idx] = stb; b_wd[idx] = wd;
        end
    endtask

    task automatic push_bus(input bit sel, input logic g0, input logic g1, input logic e0,
                            input logic e1, input logic rd, input logic wr,
                            input logic [3:0] stb, input logic [29:0] adr,
                            input bit chk_din, input logic [31:0] din);
        exp_t e;
        e.kind = 0; e.sel = sel; e.o = {g0, g1, e0, e1, rd, wr, stb, adr};
        e.chk_din = chk_din; e.din = din; e.midx = 0; e.mval = '0; e.tag = tnum;
        q.push_back(e);
    endtask

    task automatic bus(input bit sel, input logic g0, input logic g1, input logic e0,
                       input logic e1, input logic rd, input logic wr,
                       input logic [3:0] stb, input logic [29:0] adr);
        push_bus(sel, g0, g1, e0, e1, rd, wr, stb, adr, 1'b0, 32'h0);
    endtask

    task automatic idle(input bit sel);
        push_bus(sel, 0, 0, 0, 0, 0, 0, 4'h0, 30'h0, 1'b0, 32'h0);
    endtask

    task automatic memchk(input int idx, input logic [31:0] val);
        exp_t e;
        e.kind = 1; e.sel = 0; e.o = '0; e.chk_din = 0; e.din = '0;
        e.midx = idx; e.mval = val; e.tag = tnum;
        q.push_back(e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tnum   = 0;
        for (int m = 0; m < 2; m++) begin
            set_m(0, m, 0, 0, 0, 30'h0, 4'h0);
            set_m(1, m, 0, 0, 0, 30'h0, 4'h0);
        end
        reset    = 1'b1;
        mem_init = 1'b1;
        step();
        mem_init = 1'b0;

        // 1: reset held with both requests high; m0 wins first tie after release
        tnum = 1;
        set_m(0, 0, 1, 1, 0, 30'd5, 4'hF);
        set_m(0, 1, 1, 1, 0, 30'd7, 4'hF);
        idle(0);
        step(); idle(0);
        step(); reset = 1'b0; idle(0);
        step(); set_m(0, 1, 0, 0, 0, 30'h0, 4'h0);
        bus(0, 1, 0, 0, 0, 1, 0, 4'hF, 30'd5);
        step(); set_m(0, 0, 0, 0, 0, 30'd5, 4'hF);
        bus(0, 1, 0, 0, 0, 0, 0, 4'hF, 30'd5);

        // 2: m1 alone reads byte address 0x40; m0 drives junk without a grant
        tnum = 2;
        step();
        set_m(0, 1, 1, 1, 0, 30'h10, 4'hF);
        set_m(0, 0, 0, 1, 1, 30'h3FFF_FFFF, 4'h0);
        idle(0);
        step(); set_m(0, 1, 0, 1, 0, 30'h10, 4'hF);
        push_bus(0, 0, 1, 0, 0, 1, 0, 4'hF, 30'h10, 1'b1, 32'hCAFE_0010);

        // 3: continuous contention, round-robin with 8-cycle bursts, no idle gap
        tnum = 3;
        step();
        set_m(0, 0, 1, 1, 0, 30'd1, 4'hF);
        set_m(0, 1, 1, 1, 0, 30'd2, 4'hF);
        idle(0);
        for (int i = 0; i < 18; i++) begin
            bit own0;
            own0 = (i < 8) || (i >= 16);
            step();
            bus(0, own0, !own0, 0, 0, 1, 0, 4'hF, own0 ? 30'd1 : 30'd2);
        end
        step();
        set_m(0, 0, 0, 0, 0, 30'd1, 4'hF);
        set_m(0, 1, 0, 0, 0, 30'd2, 4'hF);
        bus(0, 1, 0, 0, 0, 0, 0, 4'hF, 30'd1);

        // 5: illegal accesses flag an error and never reach memory
        tnum = 5;
        step();
        set_m(0, 1, 0, 0, 0, 30'h0, 4'h0);
        set_m(0, 0, 1, 0, 1, 30'd16384, 4'hF);
        idle(0);
        step(); bus(0, 1, 0, 1, 0, 0, 0, 4'hF, 30'd16384);
        step(); set_m(0, 0, 1, 1, 1, 30'd3, 4'hF);
        bus(0, 1, 0, 1, 0, 0, 0, 4'hF, 30'd3);
        step(); set_m(0, 0, 1, 0, 1, 30'd4, 4'h0);
        bus(0, 1, 0, 1, 0, 0, 0, 4'h0, 30'd4);
        step(); set_m(0, 0, 1, 1, 0, 30'd16383, 4'hF);
        bus(0, 1, 0, 0, 0, 1, 0, 4'hF, 30'd16383);
        step(); set_m(0, 0, 0, 0, 1, 30'd6, 4'hF);
        bus(0, 1, 0, 0, 0, 0, 1, 4'hF, 30'd6);
        step();
        set_m(0, 0, 0, 0, 0, 30'h0, 4'h0);
        set_m(0, 1, 1, 1, 0, 30'd20000, 4'hF);
        idle(0);
        step(); set_m(0, 1, 0, 1, 0, 30'd20000, 4'hF);
        bus(0, 0, 1, 0, 1, 0, 0, 4'hF, 30'd20000);

        // 6: reset during an m1 write burst suppresses the write at the reset edge
        tnum = 6;
        step();
        set_m(0, 1, 1, 0, 1, 30'd8, 4'hF);
        idle(0);
        step(); bus(0, 0, 1, 0, 0, 0, 1, 4'hF, 30'd8);
        step(); set_m(0, 1, 1, 0, 1, 30'd9, 4'hF);
        bus(0, 0, 1, 0, 0, 0, 1, 4'hF, 30'd9);
        step(); set_m(0, 1, 1, 0, 1, 30'd10, 4'hF);
        set_m(0, 0, 1, 1, 0, 30'h21, 4'hF);
        reset = 1'b1;
        bus(0, 0, 1, 0, 0, 0, 0, 4'hF, 30'd10);
        step(); reset = 1'b0;
        idle(0);
        step();
        set_m(0, 0, 0, 1, 0, 30'h21, 4'hF);
        set_m(0, 1, 0, 0, 0, 30'd10, 4'hF);
        bus(0, 1, 0, 0, 0, 1, 0, 4'hF, 30'h21);
        step();
        set_m(0, 0, 0, 0, 0, 30'h0, 4'h0);
        set_m(0, 1, 0, 0, 0, 30'h0, 4'h0);
        idle(0);

        // 4: fixed priority: m0 wins the tie even right after it owned the bus
        tnum = 4;
        step();
        set_m(1, 0, 1, 1, 0, 30'd1, 4'hF);
        idle(1);
        step(); set_m(1, 0, 0, 1, 0, 30'd1, 4'hF);
        bus(1, 1, 0, 0, 0, 1, 0, 4'hF, 30'd1);
        step();
        set_m(1, 0, 1, 1, 0, 30'd1, 4'hF);
        set_m(1, 1, 1, 1, 0, 30'd2, 4'hF);
        idle(1);
        step(); set_m(1, 0, 0, 1, 0, 30'd1, 4'hF);
        bus(1, 1, 0, 0, 0, 1, 0, 4'hF, 30'd1);
        step(); set_m(1, 1, 0, 1, 0, 30'd2, 4'hF);
        bus(1, 0, 1, 0, 0, 1, 0, 4'hF, 30'd2);
        step();
        set_m(1, 0, 0, 0, 0, 30'h0, 4'h0);
        set_m(1, 1, 0, 0, 0, 30'h0, 4'h0);
        idle(1);

        // Memory contents after the write traffic
        tnum = 7;
        step();
        memchk(0, 32'hCAFE_0000);
        memchk(3, 32'hCAFE_0003);
        memchk(4, 32'hCAFE_0004);
        memchk(6, 32'h8000_0006);
        memchk(8, 32'hC000_0008);
        memchk(9, 32'hC000_0009);
        memchk(10, 32'hCAFE_000A);
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
